// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer (IDLE/FETCH/HOLD/FLUSH); optional bus timeout enabled by FETCH_TIMEOUT_EN
module fetch_seq #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] pc_in,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic [15:0] pc_din,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ack,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        fetch_err
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;
  state_t      state_q, state_d;
  logic        mem_rd_q, mem_rd_d, ir_valid_q, ir_valid_d, pc_ld_q, pc_ld_d, pc_inc_q, pc_inc_d;
  logic [15:0] mem_addr_q, mem_addr_d, ir_out_q, ir_out_d, pc_din_q, pc_din_d;
  logic        tmo, err;
`ifdef FETCH_TIMEOUT_EN
  logic        waiting, err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  assign waiting = (state_q == FETCH || state_q == FLUSH) && !mem_ready;
  assign tmo     = waiting && (cnt_q + 16'd1 == 16'(TIMEOUT_CYC));
  assign err     = err_q;
  // count consecutive stalled read cycles; the error flag is sticky until reset
  always_comb begin
    cnt_d = (waiting && !tmo) ? cnt_q + 16'd1 : 16'd0;
    err_d = err_q | tmo;
  end
  // timeout counter and error flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  // next-state and registered-output computation; a branch always strobes pc_ld and drops ir_valid
  always_comb begin
    state_d    = state_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    ir_out_d   = ir_out_q;
    ir_valid_d = ir_valid_q;
    pc_din_d   = br_taken ? br_target : pc_din_q;
    pc_ld_d    = br_taken;
    pc_inc_d   = 1'b0;
    if (br_taken) ir_valid_d = 1'b0;
    case (state_q)
      IDLE: if (!br_taken && en && !err) begin
        state_d    = FETCH;
        mem_rd_d   = 1'b1;
        mem_addr_d = pc_in;
      end
      FETCH: if (br_taken) begin
        state_d  = mem_ready ? IDLE : FLUSH;
        mem_rd_d = !mem_ready;
      end else if (mem_ready) begin
        state_d    = HOLD;
        mem_rd_d   = 1'b0;
        ir_out_d   = mem_data;
        ir_valid_d = 1'b1;
        pc_inc_d   = 1'b1;
      end
      HOLD: if (br_taken || ir_ack) begin
        state_d    = IDLE;
        ir_valid_d = 1'b0;
      end
      FLUSH: if (mem_ready) begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d  = IDLE;
      mem_rd_d = 1'b0;
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 16'd0;
      ir_out_q   <= 16'd0;
      ir_valid_q <= 1'b0;
      pc_ld_q    <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_din_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      ir_out_q   <= ir_out_d;
      ir_valid_q <= ir_valid_d;
      pc_ld_q    <= pc_ld_d;
      pc_inc_q   <= pc_inc_d;
      pc_din_q   <= pc_din_d;
    end
  end
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign ir_out    = ir_out_q;
  assign ir_valid  = ir_valid_q;
  assign pc_ld     = pc_ld_q;
  assign pc_inc    = pc_inc_q;
  assign pc_din    = pc_din_q;
  assign fetch_err = err;
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed and randomized checks of fetch_seq against a transaction-level model
module tb_fetch_seq;
  logic clk = 0, reset = 1, en = 0, mem_ready = 0, ir_ack = 0, br_taken = 0;
  logic [15:0] pc_in = 0, mem_data = 0, br_target = 0;
  logic pc_ld, pc_inc, mem_rd, ir_valid, fetch_err;
  logic [15:0] pc_din, mem_addr, ir_out;
  int n_cmp = 0, n_bad = 0;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TMO = 1;
`else
  localparam bit TMO = 0;
`endif
  localparam int TCYC = 16;

  fetch_seq #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .reset(reset), .en(en), .pc_in(pc_in), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_din(pc_din), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_data(mem_data), .ir_out(ir_out), .ir_valid(ir_valid), .ir_ack(ir_ack),
    .br_taken(br_taken), .br_target(br_target), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  wire [52:0] obs = {mem_rd, mem_addr, ir_out, ir_valid, pc_ld, pc_inc, pc_din, fetch_err};

  // model: a read is outstanding (busy), possibly to be dropped; or an instruction is held
  bit m_busy, m_drop, m_hold, m_err;
  int m_miss;
  logic x_rd, x_iv, x_ld, x_inc;
  logic [15:0] x_addr, x_ir, x_din, pc;

  function automatic logic [52:0] expv();
    return {x_rd, x_addr, x_ir, x_iv, x_ld, x_inc, x_din, m_err};
  endfunction

  task automatic model_reset();
    {m_busy, m_drop, m_hold, m_err} = 0;
    m_miss = 0;
    {x_rd, x_iv, x_ld, x_inc} = 0;
    {x_addr, x_ir, x_din} = 0;
  endtask

  task automatic step(input bit e, input bit r, input logic [15:0] d, input bit b,
                      input logic [15:0] t, input bit a);
    logic [15:0] pc_nx;
    en = e; mem_ready = r; mem_data = d; br_taken = b; br_target = t; ir_ack = a; pc_in = pc;
    pc_nx = x_ld ? x_din : x_inc ? pc + 16'd1 : pc;
    x_ld = b;
    x_inc = 0;
    if (b) begin x_din = t; x_iv = 0; end
    if (m_busy) begin
      if (r) begin
        m_miss = 0;
        if (!m_drop && !b) begin x_ir = d; x_iv = 1; x_inc = 1; m_hold = 1; end
        m_busy = 0; m_drop = 0; x_rd = 0;
      end else begin
        if (b) m_drop = 1;
        m_miss++;
        if (TMO && m_miss == TCYC) begin m_err = 1; m_busy = 0; m_drop = 0; m_miss = 0; x_rd = 0; end
      end
    end else if (m_hold) begin
      if (b || a) begin m_hold = 0; x_iv = 0; end
    end else if (e && !b && !m_err) begin
      m_busy = 1; x_rd = 1; x_addr = pc;
    end
    @(posedge clk);
    pc = pc_nx;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0; en = 0; br_taken = 0; ir_ack = 0; mem_ready = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    #2 reset = 0;
    #1;
    n_cmp++;
    if (obs !== 53'd0) begin n_bad++; $display("FAIL reset_state: got %h want 0", obs); end
    model_reset();
    pc = 16'h0010;
    @(negedge clk);
    reset = 1;
    n_cmp++;
    if (obs !== 53'd0) begin n_bad++; $display("FAIL reset_release: got %h want 0", obs); end
  endtask

  task automatic test_basic_fetch();
    int incs = 0;
    step(1, 0, 16'h0, 0, 16'h0, 0);
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0010) begin
      n_bad++; $display("FAIL first_fetch: got rd=%b addr=%h want rd=1 addr=0010", mem_rd, mem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 16'hFFFF, 0, 16'h0, 0);
      incs += int'(pc_inc);
      n_cmp++;
      if (obs !== expv()) begin n_bad++; $display("FAIL fetch_wait: got %h want %h", obs, expv()); end
    end
    step(1, 1, 16'hA5C3, 0, 16'h0, 0);
    incs += int'(pc_inc);
    n_cmp++;
    if (ir_out !== 16'hA5C3 || ir_valid !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0010) begin
      n_bad++; $display("FAIL fetch_done: got ir=%h v=%b rd=%b addr=%h want A5C3 1 0 0010", ir_out, ir_valid, mem_rd, mem_addr);
    end
    step(1, 0, 16'h0, 0, 16'h0, 0);
    incs += int'(pc_inc);
    n_cmp++;
    if (incs != 1) begin n_bad++; $display("FAIL pc_inc_pulse: got %0d pulses want 1", incs); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 16'h1234, 0, 16'h0, 0);
      n_cmp++;
      if (ir_out !== 16'hA5C3 || ir_valid !== 1'b1 || mem_rd !== 1'b0) begin
        n_bad++; $display("FAIL hold_stable: got ir=%h v=%b rd=%b want A5C3 1 0", ir_out, ir_valid, mem_rd);
      end
    end
    step(1, 0, 16'h0, 0, 16'h0, 1);
    n_cmp++;
    if (ir_valid !== 1'b0 || obs !== expv()) begin
      n_bad++; $display("FAIL hold_ack: got %h want %h", obs, expv());
    end
    step(1, 0, 16'h0, 0, 16'h0, 0);
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0011) begin
      n_bad++; $display("FAIL next_fetch_addr: got rd=%b addr=%h want 1 0011", mem_rd, mem_addr);
    end
    step(1, 1, 16'h0BAD, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0, 16'h0, 1);
    n_cmp++;
    if (obs !== expv()) begin n_bad++; $display("FAIL second_fetch: got %h want %h", obs, expv()); end
  endtask

  task automatic test_branch_flush();
    int incs = 0;
    pc = 16'h0020;
    step(1, 0, 16'h0, 0, 16'h0, 0);
    n_cmp++;
    if (mem_addr !== 16'h0020) begin n_bad++; $display("FAIL flush_addr: got %h want 0020", mem_addr); end
    step(1, 0, 16'h0, 1, 16'h0100, 0);
    n_cmp++;
    if (pc_ld !== 1'b1 || pc_din !== 16'h0100 || mem_rd !== 1'b1) begin
      n_bad++; $display("FAIL flush_branch: got ld=%b din=%h rd=%b want 1 0100 1", pc_ld, pc_din, mem_rd);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, i == 2, 16'hDEAD, 0, 16'h0, 0);
      incs += int'(pc_inc);
      n_cmp++;
      if (pc_ld !== 1'b0 || ir_valid !== 1'b0) begin
        n_bad++; $display("FAIL flush_drain: got ld=%b v=%b want 0 0", pc_ld, ir_valid);
      end
    end
    step(1, 0, 16'h0, 0, 16'h0, 0);
    n_cmp++;
    if (incs != 0 || mem_addr !== 16'h0100 || mem_rd !== 1'b1) begin
      n_bad++; $display("FAIL flush_redirect: got incs=%0d addr=%h rd=%b want 0 0100 1", incs, mem_addr, mem_rd);
    end
    step(1, 1, 16'h7777, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0, 16'h0, 1);
    n_cmp++;
    if (obs !== expv()) begin n_bad++; $display("FAIL flush_tail: got %h want %h", obs, expv()); end
  endtask

  task automatic test_branch_ready();
    step(1, 0, 16'h0, 0, 16'h0, 0);
    step(1, 1, 16'h5555, 1, 16'h0200, 0);
    n_cmp++;
    if (pc_ld !== 1'b1 || pc_inc !== 1'b0 || ir_valid !== 1'b0 || mem_rd !== 1'b0 || pc_din !== 16'h0200) begin
      n_bad++; $display("FAIL br_and_ready: got ld=%b inc=%b v=%b rd=%b din=%h want 1 0 0 0 0200", pc_ld, pc_inc, ir_valid, mem_rd, pc_din);
    end
    step(0, 0, 16'h0, 0, 16'h0, 0);
    n_cmp++;
    if (ir_valid !== 1'b0 || pc_inc !== 1'b0 || obs !== expv()) begin
      n_bad++; $display("FAIL br_and_ready_after: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 16'h0, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0, 16'h0, 0);
    n_cmp++;
    if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL pre_async: got rd=%b want 1", mem_rd); end
    reset = 0;
    #1;
    n_cmp++;
    if (obs !== 53'd0) begin n_bad++; $display("FAIL async_reset: got %h want 0", obs); end
    do_reset();
  endtask

  task automatic test_timeout();
    step(1, 0, 16'h0, 0, 16'h0, 0);
    for (int i = 0; i < 19; i++) begin
      step(1, 0, 16'h0, 0, 16'h0, 0);
      n_cmp++;
      if (obs !== expv()) begin n_bad++; $display("FAIL timeout_cycle%0d: got %h want %h", i, obs, expv()); end
    end
`ifdef FETCH_TIMEOUT_EN
    n_cmp++;
    if (fetch_err !== 1'b1 || mem_rd !== 1'b0) begin
      n_bad++; $display("FAIL timeout_err: got err=%b rd=%b want 1 0", fetch_err, mem_rd);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 16'h0, 0, 16'h0, 0);
    n_cmp++;
    if (fetch_err !== 1'b1 || mem_rd !== 1'b0) begin
      n_bad++; $display("FAIL timeout_sticky: got err=%b rd=%b want 1 0", fetch_err, mem_rd);
    end
`else
    n_cmp++;
    if (fetch_err !== 1'b0 || mem_rd !== 1'b1) begin
      n_bad++; $display("FAIL no_timeout: got err=%b rd=%b want 0 1", fetch_err, mem_rd);
    end
    step(1, 1, 16'h0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0, 16'h0, 1);
`endif
    do_reset();
    step(1, 0, 16'h0, 0, 16'h0, 0);
    n_cmp++;
    if (fetch_err !== 1'b0 || mem_rd !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_fetch: got err=%b rd=%b want 0 1", fetch_err, mem_rd);
    end
    step(0, 1, 16'h0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0, 16'h0, 1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      int rp = (i < 2500) ? 50 : 25;
      step($urandom_range(99) < 80, $urandom_range(99) < rp, 16'($urandom), $urandom_range(99) < 10,
           16'($urandom), $urandom_range(1));
      n_cmp++;
      if (obs !== expv() || (pc_ld && pc_inc)) begin
        n_bad++; bad++;
        if (bad <= 10) $display("FAIL random_cycle%0d: got %h want %h", i, obs, expv());
      end
    end
  endtask

  initial begin
    model_reset();
    pc = 0;
    test_reset();
    test_basic_fetch();
    test_hold();
    test_branch_flush();
    test_branch_ready();
    test_async_reset();
    test_timeout();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
